// File: rtl/udp_gen_pkg.sv
// Shared definitions for the packet-generator datapath: sequencer states,
// fill-mode encodings and the payload length limit used to size the checksum FIFO.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam logic FILL_CONST = 1'b0;
  localparam logic FILL_INCR  = 1'b1;

  localparam int unsigned DEFAULT_MAX_LEN = 1472;

endpackage

// File: rtl/udp_pkt_sequencer.sv
// Run-time configurable packet scheduler feeding the UDP checksum generator's
// header and payload streams: length, fill, gap, count, IP id and start/stop.
module udp_pkt_sequencer
  import udp_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN    = DEFAULT_MAX_LEN,
  parameter logic [7:0]  FILL_BYTE  = 8'h11,
  parameter logic [15:0] IP_ID_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_len,
  input  logic [15:0] cfg_gap,
  input  logic [31:0] cfg_count,
  input  logic        cfg_incr,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [15:0] ip_id,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic        tuser,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkt_sent
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] count_q, count_d;
  logic        incr_q, incr_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] pkt_sent_d;
  logic [15:0] ip_id_d;
  logic        stop_q, stop_d;
  logic        done_d;
  logic        last_beat;

  assign tuser     = 1'b0;
  assign last_beat = (byte_cnt_q == len_q - 16'd1);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    gap_d      = gap_q;
    count_d    = count_q;
    incr_d     = incr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_sent_d = pkt_sent;
    ip_id_d    = ip_id;
    stop_d     = stop_q | (stop && (state_q != ST_IDLE));
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len == 16'd0)          len_d = 16'd1;
          else if (cfg_len > MAX_LEN_W)  len_d = MAX_LEN_W;
          else                           len_d = cfg_len;
          gap_d      = cfg_gap;
          count_d    = cfg_count;
          incr_d     = cfg_incr;
          pkt_sent_d = 32'd0;
          stop_d     = 1'b0;
          state_d    = ST_HDR;
        end
      end

      // A pending stop never withdraws the header; the packet goes out whole.
      ST_HDR: begin
        if (hdr_ready) begin
          byte_cnt_d = 16'd0;
          state_d    = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (tready) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (last_beat) begin
            pkt_sent_d = pkt_sent + 32'd1;
            ip_id_d    = ip_id + 16'd1;
            if (stop_d || ((count_q != 32'd0) && (pkt_sent_d == count_q))) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (gap_q == 16'd0) begin
              state_d = ST_HDR;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (stop_d) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
          if (gap_cnt_q == 16'd1) state_d = ST_HDR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; outputs are decoded from next-state so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'd1;
      gap_q      <= 16'd0;
      count_q    <= 32'd0;
      incr_q     <= FILL_CONST;
      byte_cnt_q <= 16'd0;
      gap_cnt_q  <= 16'd0;
      stop_q     <= 1'b0;
      hdr_valid  <= 1'b0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      tdata      <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      pkt_sent   <= 32'd0;
      ip_id      <= IP_ID_INIT;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      incr_q     <= incr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      stop_q     <= stop_d;
      pkt_sent   <= pkt_sent_d;
      ip_id      <= ip_id_d;
      done       <= done_d;
      busy       <= (state_d != ST_IDLE);
      hdr_valid  <= (state_d == ST_HDR);
      tvalid     <= (state_d == ST_PAYLOAD);
      tlast      <= (state_d == ST_PAYLOAD) && (byte_cnt_d == len_d - 16'd1);
      // Byte count only moves on a handshake, so stalled beats hold tdata/tlast.
      if (state_d == ST_PAYLOAD)
        tdata <= (incr_d == FILL_INCR) ? byte_cnt_d[7:0] : FILL_BYTE;
    end
  end

endmodule

// File: tb/tb_udp_pkt_sequencer.sv
// Self-checking bench: a monitor logs header/beat/done transactions and each
// run is compared against packet lists and timing computed from the rules.
module tb_udp_pkt_sequencer;

  localparam int MAX_LEN = 1472;

  logic        clk, reset, start, stop;
  logic [15:0] cfg_len, cfg_gap;
  logic [31:0] cfg_count;
  logic        cfg_incr;
  logic        hdr_valid, hdr_ready;
  logic [15:0] ip_id;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser, busy, done;
  logic [31:0] pkt_sent;

  udp_pkt_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_incr(cfg_incr),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .ip_id(ip_id),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast), .tuser(tuser),
    .busy(busy), .done(done), .pkt_sent(pkt_sent)
  );

  typedef struct { int cyc; logic [15:0] ip; } hdr_t;
  typedef struct { int cyc; logic [7:0] data; logic last; } beat_t;

  hdr_t  hdr_q[$];
  beat_t beat_q[$];
  int    hr_q[$];     // cycles where hdr_valid rises
  int    tv_q[$];     // cycles where tvalid rises
  int    done_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cyc;
  bit          bp_mode = 0;
  logic [15:0] m_ip = 16'h0000;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready lines: always high, or random when backpressure is enabled.
  initial begin
    tready = 1'b1;
    hdr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready    = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      hdr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Transaction monitor, sampled mid-cycle.
  logic       p_hv = 0, p_hr = 0, p_tv = 0, p_tr = 0, p_last = 0;
  logic [7:0] p_data = 0;
  logic [15:0] p_ip = 0;

  always @(negedge clk) begin
    if (reset) begin
      p_hv = 0; p_hr = 0; p_tv = 0; p_tr = 0;
    end else begin
      if (hdr_valid && !p_hv) hr_q.push_back(cyc);
      if (tvalid && !p_tv)    tv_q.push_back(cyc);
      if (p_hv && !p_hr)      check("hdr_held", hdr_valid, 1);
      if (p_hv && hdr_valid)  check("ip_stable", ip_id, p_ip);
      if (p_tv && !p_tr) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata", tdata, p_data);
        check("stall_tlast", tlast, p_last);
      end
      if (hdr_valid && hdr_ready) hdr_q.push_back('{cyc: cyc, ip: ip_id});
      if (tvalid && tready)       beat_q.push_back('{cyc: cyc, data: tdata, last: tlast});
      if (done) begin
        done_q.push_back(cyc);
        check("done_busy", busy, 0);
      end
      p_hv = hdr_valid; p_hr = hdr_ready; p_tv = tvalid; p_tr = tready;
      p_data = tdata; p_last = tlast; p_ip = ip_id;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_hdr_valid"}, hdr_valid, 0);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_tuser"}, tuser, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tdata"}, tdata, 0);
    check({tag, "_pkt_sent"}, pkt_sent, 0);
    check({tag, "_ip_id"}, ip_id, 16'h0000);
  endtask

  task automatic start_run(input int len, input int gap, input int count, input bit incr, input bit bp);
    hdr_q.delete(); beat_q.delete(); hr_q.delete(); tv_q.delete(); done_q.delete();
    bp_mode   = bp;
    cfg_len   = 16'(len);
    cfg_gap   = 16'(gap);
    cfg_count = 32'(count);
    cfg_incr  = incr;
    start     = 1'b1;
    start_cyc = cyc;
    step();
    start     = 1'b0;
    // Config inputs are only sampled at start; scramble them for the rest of the run.
    cfg_len   = 16'($urandom);
    cfg_gap   = 16'($urandom);
    cfg_count = $urandom;
    cfg_incr  = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_q.size() == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_q.size() == 0) check("done_timeout", 0, 1);
    bp_mode = 0;
    step();
    step();
  endtask

  // stop_cyc < 0: run ends at its last beat; otherwise a stop was issued in GAP at stop_cyc.
  task automatic verify(input int len_cfg, input int gap, input bit incr, input bit bp,
                        input int npkts, input int stop_cyc);
    int len;
    int b;
    len = (len_cfg == 0) ? 1 : ((len_cfg > MAX_LEN) ? MAX_LEN : len_cfg);
    check("hdr_count", hdr_q.size(), npkts);
    check("beat_count", beat_q.size(), npkts * len);
    check("done_count", done_q.size(), 1);
    check("pkt_sent", pkt_sent, npkts);
    check("ip_id_end", ip_id, 16'(m_ip + 16'(npkts)));
    if (hdr_q.size() == npkts && beat_q.size() == npkts * len && done_q.size() == 1 &&
        hr_q.size() == npkts && tv_q.size() == npkts) begin
      check("start_to_hdr", hr_q[0], start_cyc + 1);
      for (int p = 0; p < npkts; p++) begin
        check("hdr_ip_id", hdr_q[p].ip, 16'(m_ip + 16'(p)));
        check("hdr_to_tvalid", tv_q[p], hdr_q[p].cyc + 1);
        if (p > 0) check("gap_timing", hr_q[p], beat_q[p * len - 1].cyc + gap + 1);
        for (int i = 0; i < len; i++) begin
          b = p * len + i;
          check("tdata", beat_q[b].data, incr ? 8'(i) : 8'h11);
          check("tlast", beat_q[b].last, (i == len - 1));
          if (!bp) check("no_bubble", beat_q[b].cyc, tv_q[p] + i);
        end
      end
      if (stop_cyc < 0) check("done_timing", done_q[0], beat_q[npkts * len - 1].cyc + 1);
      else              check("done_timing", done_q[0], stop_cyc + 1);
    end else begin
      check("transaction_shape", 0, 1);
    end
    m_ip = 16'(m_ip + 16'(npkts));
  endtask

  initial begin
    int n, s, len, gap, cnt;
    bit incr, bp;
    reset = 1; start = 0; stop = 0;
    cfg_len = 0; cfg_gap = 0; cfg_count = 0; cfg_incr = 0;
    step(); step(); step();
    check_reset_state("por");
    reset = 0;
    step();

    // Single packet, constant fill.
    start_run(18, 0, 1, 0, 0);
    wait_done(200);
    verify(18, 0, 0, 0, 1, -1);

    // Incrementing fill with random backpressure.
    start_run(300, 0, 1, 1, 1);
    wait_done(5000);
    verify(300, 0, 1, 1, 1, -1);

    // Stop in IDLE is ignored; then gap and count.
    stop = 1; step(); stop = 0; step();
    start_run(10, 5, 3, 0, 0);
    wait_done(500);
    verify(10, 5, 0, 0, 3, -1);

    // Continuous, stop mid-payload of packet 4.
    start_run(20, 2, 0, 0, 0);
    n = 0;
    while (hdr_q.size() < 4 && n < 500) begin step(); n++; end
    check("wait_pkt4", hdr_q.size() >= 4, 1);
    repeat (5) step();
    stop = 1; step(); stop = 0;
    wait_done(500);
    verify(20, 2, 0, 0, 4, -1);

    // Continuous, stop during GAP after packet 2.
    start_run(8, 10, 0, 1, 0);
    n = 0;
    while (beat_q.size() < 16 && n < 500) begin step(); n++; end
    check("wait_gap", beat_q.size(), 16);
    stop = 1; s = cyc; step(); stop = 0;
    wait_done(500);
    verify(8, 10, 1, 0, 2, s);

    // Length clamping.
    start_run(0, 0, 2, 0, 1);
    wait_done(500);
    verify(0, 0, 0, 1, 2, -1);
    start_run(2000, 0, 1, 1, 0);
    wait_done(5000);
    verify(2000, 0, 1, 0, 1, -1);

    // Start while busy is ignored.
    start_run(10, 3, 2, 0, 0);
    repeat (4) step();
    start = 1; step(); start = 0;
    wait_done(500);
    verify(10, 3, 0, 0, 2, -1);

    // Random runs.
    for (int r = 0; r < 6; r++) begin
      len  = $urandom_range(1, 40);
      gap  = $urandom_range(0, 4);
      cnt  = $urandom_range(1, 3);
      incr = 1'($urandom_range(0, 1));
      bp   = 1'($urandom_range(0, 1));
      start_run(len, gap, cnt, incr, bp);
      wait_done(3000);
      verify(len, gap, incr, bp, cnt, -1);
    end

    // Reset mid-payload, then a normal run from the initial IP id.
    start_run(100, 0, 0, 0, 0);
    n = 0;
    while (beat_q.size() < 10 && n < 500) begin step(); n++; end
    reset = 1; step(); reset = 0;
    check_reset_state("mid_reset");
    m_ip = 16'h0000;
    step();
    start_run(5, 0, 1, 0, 0);
    wait_done(200);
    verify(5, 0, 0, 0, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
